// File: rtl/ram_port_arbiter.sv
// Two-master arbiter in front of a single-port RAM with 1-cycle registered read.
// Round-robin with a burst limit; define RAM_ARB_FIXED_PRIO_EN for fixed priority to master 0.
module ram_port_arbiter #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 4,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              ram_write_en,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_write_data,
  input  logic [DATA_W-1:0] ram_read_data
);

  localparam logic [3:0] LP_MAX = 4'(MAX_BURST);

  logic       r_owner;
  logic [3:0] r_burst_cnt;
  logic [1:0] r_rd_pend;

  logic w_grant0;
  logic w_grant1;
  logic w_continue;
  logic w_pick1;

  // A non-zero count means the owner was granted last cycle and may keep the port.
  assign w_continue = (r_burst_cnt != 4'd0) && (r_burst_cnt < LP_MAX);
  assign w_pick1    = w_continue ? r_owner : ~r_owner;

  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (rst_n) begin
      if (req0 && !req1) begin
        w_grant0 = 1'b1;
      end else if (req1 && !req0) begin
        w_grant1 = 1'b1;
      end else if (req0 && req1) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
        w_grant0 = 1'b1;
`else
        w_grant0 = ~w_pick1;
        w_grant1 = w_pick1;
`endif
      end
    end
  end

  assign ack0 = w_grant0;
  assign ack1 = w_grant1;

  always_comb begin
    ram_write_en   = 1'b0;
    ram_address    = '0;
    ram_write_data = '0;
    if (w_grant0) begin
      ram_write_en   = we0;
      ram_address    = addr0;
      ram_write_data = wdata0;
    end else if (w_grant1) begin
      ram_write_en   = we1;
      ram_address    = addr1;
      ram_write_data = wdata1;
    end
  end

  // Gating with rst_n drops a read return that collides with reset.
  assign rvalid0 = r_rd_pend[0] & rst_n;
  assign rvalid1 = r_rd_pend[1] & rst_n;
  assign rdata0  = rvalid0 ? ram_read_data : '0;
  assign rdata1  = rvalid1 ? ram_read_data : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_owner     <= 1'b1;
      r_burst_cnt <= 4'd0;
      r_rd_pend   <= 2'b00;
    end else begin
      r_rd_pend <= {w_grant1 & ~we1, w_grant0 & ~we0};
      if (w_grant0 || w_grant1) begin
        if (w_grant1 == r_owner) begin
          if (r_burst_cnt < LP_MAX) begin
            r_burst_cnt <= r_burst_cnt + 4'd1;
          end
        end else begin
          r_owner     <= w_grant1;
          r_burst_cnt <= 4'd1;
        end
      end else begin
        r_burst_cnt <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural RAM and a read-return scoreboard.
module tb_ram_port_arbiter;

`ifdef RAM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [3:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
  logic       ack0, ack1, rvalid0, rvalid1, ram_write_en;
  logic [3:0] rdata0, rdata1, ram_address, ram_write_data;
  logic [3:0] ram_read_data = '0;

  logic [3:0] tb_mem [16];
  logic [3:0] sh_mem [16];
  logic [3:0] exp_q0 [$];
  logic [3:0] exp_q1 [$];
  logic       pend0 = 1'b0, pend1 = 1'b0;
  int         n_pass = 0, n_fail = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.ADDR_W(4), .DATA_W(4), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1),
    .ram_write_en(ram_write_en), .ram_address(ram_address),
    .ram_write_data(ram_write_data), .ram_read_data(ram_read_data)
  );

  // Single-port RAM: registered read, read-before-write; contents reload to mem[i]=i in reset.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) tb_mem[i] <= 4'(i);
      ram_read_data <= '0;
    end else begin
      ram_read_data <= tb_mem[ram_address];
      if (ram_write_en) tb_mem[ram_address] <= ram_write_data;
    end
  end

  task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
    assert (got === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input logic rst,
                      input logic r0, input logic w0, input logic [3:0] a0, input logic [3:0] d0,
                      input logic r1, input logic w1, input logic [3:0] a1, input logic [3:0] d1,
                      input logic e0, input logic e1);
    logic [3:0] v0, v1;
    logic [9:0] exp_port;
    @(posedge clk);
    #1;
    rst_n = rst;
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    @(negedge clk);
    v0 = '0;
    v1 = '0;
    if (pend0) begin
      v0 = exp_q0.pop_front();
      if (!rst) v0 = '0;
    end
    if (pend1) begin
      v1 = exp_q1.pop_front();
      if (!rst) v1 = '0;
    end
    chk("rvalid0", 10'(rvalid0), 10'(pend0 & rst));
    chk("rdata0", 10'(rdata0), 10'(v0));
    chk("rvalid1", 10'(rvalid1), 10'(pend1 & rst));
    chk("rdata1", 10'(rdata1), 10'(v1));
    chk("ack0", 10'(ack0), 10'(e0));
    chk("ack1", 10'(ack1), 10'(e1));
    exp_port = e0 ? {1'b0, w0, a0, d0} : e1 ? {1'b0, w1, a1, d1} : 10'd0;
    chk("ram_port", {1'b0, ram_write_en, ram_address, ram_write_data}, exp_port);
    pend0 = e0 & ~w0;
    pend1 = e1 & ~w1;
    if (pend0) exp_q0.push_back(sh_mem[a0]);
    if (pend1) exp_q1.push_back(sh_mem[a1]);
    if (e0 && w0) sh_mem[a0] = d0;
    if (e1 && w1) sh_mem[a1] = d1;
    if (!rst) begin
      for (int i = 0; i < 16; i++) sh_mem[i] = 4'(i);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) sh_mem[i] = 4'(i);

    // Reset held with both requesting: nothing granted, nothing returned.
    step(0, 1, 0, 4'd1, 4'd0, 1, 0, 4'd2, 4'd0, 0, 0);
    step(0, 1, 0, 4'd1, 4'd0, 1, 0, 4'd2, 4'd0, 0, 0);

    // Single master write then read-back.
    step(1, 1, 1, 4'd3, 4'hA, 0, 0, 4'd0, 4'd0, 1, 0);
    step(1, 1, 0, 4'd3, 4'd0, 0, 0, 4'd0, 4'd0, 1, 0);
    step(1, 0, 0, 4'd0, 4'd0, 0, 0, 4'd0, 4'd0, 0, 0);

    // Burst limit from reset: 0,0,0,0,1,1,1,1,0.
    step(0, 0, 0, 4'd0, 4'd0, 0, 0, 4'd0, 4'd0, 0, 0);
    for (int i = 0; i < 9; i++) begin
      logic g0;
      g0 = FIXED ? 1'b1 : ((i < 4) || (i == 8));
      step(1, 1, 0, 4'(i), 4'd0, 1, 0, 4'(15 - i), 4'd0, g0, ~g0);
    end
    step(1, 0, 0, 4'd0, 4'd0, 0, 0, 4'd0, 4'd0, 0, 0);

    // Write/read race on addr 7; owner is 0 with a broken streak, so the tie goes to 1.
    step(1, 1, 0, 4'd7, 4'd0, 1, 1, 4'd7, 4'h5, FIXED, ~FIXED);
    if (FIXED) step(1, 0, 0, 4'd0, 4'd0, 1, 1, 4'd7, 4'h5, 0, 1);
    else       step(1, 1, 0, 4'd7, 4'd0, 0, 0, 4'd0, 4'd0, 1, 0);
    // Read ahead of a competing write returns the prior contents.
    step(1, 1, 0, 4'd7, 4'd0, 1, 1, 4'd7, 4'h9, 1, 0);
    step(1, 0, 0, 4'd0, 4'd0, 1, 1, 4'd7, 4'h9, 0, 1);
    step(1, 1, 0, 4'd7, 4'd0, 0, 0, 4'd0, 4'd0, 1, 0);

    // Reset right after a read ack drops the return; first tie afterwards goes to 0.
    step(1, 0, 0, 4'd0, 4'd0, 1, 0, 4'd4, 4'd0, 0, 1);
    step(0, 1, 0, 4'd1, 4'd0, 1, 0, 4'd2, 4'd0, 0, 0);
    step(1, 1, 0, 4'd1, 4'd0, 1, 0, 4'd2, 4'd0, 1, 0);

    // Random single-master traffic: back-to-back reads/writes with alternating owners.
    for (int i = 0; i < 24; i++) begin
      logic       who, w;
      logic [3:0] a, d;
      who = 1'($urandom_range(0, 1));
      w   = ($urandom_range(0, 3) == 0);
      a   = 4'($urandom_range(0, 15));
      d   = 4'($urandom_range(0, 15));
      if (who) step(1, 0, 0, 4'd0, 4'd0, 1, w, a, d, 0, 1);
      else     step(1, 1, w, a, d, 0, 0, 4'd0, 4'd0, 1, 0);
    end
    step(1, 0, 0, 4'd0, 4'd0, 0, 0, 4'd0, 4'd0, 0, 0);
    step(1, 0, 0, 4'd0, 4'd0, 0, 0, 4'd0, 4'd0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

endmodule
